// File: rtl/muldiv_if.sv
// Handshake bundle between the EX-stage pipeline control and the HI/LO multiply/divide sequencer.
interface muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             advance;
  logic             flush;
  logic             ex_stall;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, src_a, src_b, advance, flush,
    input  ex_stall, done, hi, lo
  );

  modport slave (
    input  start, op, src_a, src_b, advance, flush,
    output ex_stall, done, hi, lo
  );
endinterface

// File: rtl/muldiv_ctrl.sv
// EX-stage HI/LO sequencer: registered multiplier plus radix-2 restoring divider, stalling EX until done.
// Optional macro DIV_EARLY_OUT_EN: finish trivial divides (|a| < |b| or a == 0) one cycle after start.
module muldiv_ctrl #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 3
) (
  input logic     clk,
  input logic     rst_n,
  muldiv_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIXUP, S_DONE} state_t;

  state_t                state;
  logic [CNT_W-1:0]      count;
  logic [WIDTH-1:0]      mag_b;
  logic [WIDTH-1:0]      raw_a;
  logic [WIDTH-1:0]      quo;
  logic [WIDTH-1:0]      rem;
  logic                  sign_a;
  logic                  sign_b;
  logic                  div_zero;
  logic [2*WIDTH-1:0]    prod_p0;

  logic                  is_signed_in;
  logic [WIDTH-1:0]      in_mag_a;
  logic [WIDTH-1:0]      in_mag_b;
  logic signed [2*WIDTH-1:0] ext_a;
  logic signed [2*WIDTH-1:0] ext_b;
  logic signed [2*WIDTH-1:0] prod_full;
  logic [WIDTH:0]        rem_sh;
  logic [WIDTH:0]        trial;
  logic                  early_out;

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic is_signed);
    return (is_signed && v[WIDTH-1]) ? -v : v;
  endfunction

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  assign is_signed_in = ~bus.op[0];
  assign in_mag_a     = magnitude(bus.src_a, is_signed_in);
  assign in_mag_b     = magnitude(bus.src_b, is_signed_in);
  assign ext_a        = {{WIDTH{is_signed_in & bus.src_a[WIDTH-1]}}, bus.src_a};
  assign ext_b        = {{WIDTH{is_signed_in & bus.src_b[WIDTH-1]}}, bus.src_b};
  assign prod_full    = ext_a * ext_b;

  // One restoring step: shift in the next dividend bit, keep the difference if it did not borrow.
  assign rem_sh = {rem, quo[WIDTH-1]};
  assign trial  = rem_sh - {1'b0, mag_b};

`ifdef DIV_EARLY_OUT_EN
  assign early_out = (in_mag_a < in_mag_b) || (bus.src_a == '0);
`else
  assign early_out = 1'b0;
`endif

  assign bus.ex_stall = ~bus.flush &&
                        ((state == S_IDLE && bus.start) || state == S_MUL ||
                         state == S_DIV || state == S_FIXUP);

  // Control path and visible results
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      count    <= '0;
      bus.done <= 1'b0;
      bus.hi   <= '0;
      bus.lo   <= '0;
    end else if (bus.flush) begin
      state    <= S_IDLE;
      count    <= '0;
      bus.done <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            if (!bus.op[1]) begin
              if (MUL_LAT == 1) begin
                state    <= S_DONE;
                bus.done <= 1'b1;
                bus.hi   <= prod_full[2*WIDTH-1:WIDTH];
                bus.lo   <= prod_full[WIDTH-1:0];
              end else begin
                state <= S_MUL;
                count <= CNT_W'(MUL_LAT - 1);
              end
            end else if (early_out) begin
              state    <= S_DONE;
              bus.done <= 1'b1;
              bus.hi   <= bus.src_a;
              bus.lo   <= '0;
            end else begin
              state <= S_DIV;
              count <= CNT_W'(WIDTH);
            end
          end
        end
        S_MUL: begin
          count <= count - CNT_W'(1);
          if (count == CNT_W'(1)) begin
            state    <= S_DONE;
            bus.done <= 1'b1;
            bus.hi   <= prod_p0[2*WIDTH-1:WIDTH];
            bus.lo   <= prod_p0[WIDTH-1:0];
          end
        end
        S_DIV: begin
          count <= count - CNT_W'(1);
          if (count == CNT_W'(1)) state <= S_FIXUP;
        end
        S_FIXUP: begin
          state    <= S_DONE;
          bus.done <= 1'b1;
          if (div_zero) begin
            bus.hi <= raw_a;
            bus.lo <= '1;
          end else begin
            bus.hi <= cond_neg(rem, sign_a);
            bus.lo <= cond_neg(quo, sign_a ^ sign_b);
          end
        end
        S_DONE: begin
          if (bus.advance) begin
            state    <= S_IDLE;
            bus.done <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Operand capture at T0 and divider datapath
  always_ff @(posedge clk) begin
    if (state == S_IDLE) begin
      mag_b    <= in_mag_b;
      raw_a    <= bus.src_a;
      sign_a   <= is_signed_in & bus.src_a[WIDTH-1];
      sign_b   <= is_signed_in & bus.src_b[WIDTH-1];
      div_zero <= (bus.src_b == '0);
      quo      <= in_mag_a;
      rem      <= '0;
      prod_p0  <= prod_full;
    end else if (state == S_DIV) begin
      rem <= trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
      quo <= {quo[WIDTH-2:0], ~trial[WIDTH]};
    end
  end
endmodule
